coin_credit_return_ctrl: RTL and testbench

//   Parametrised credit/change controller for the vending machine datapath. Accumulates inserted

---
 rtl/coin_credit_return_ctrl_pkg.sv | 21 ++
 rtl/coin_credit_return_ctrl_picker.sv | 29 ++
 rtl/coin_credit_return_ctrl.sv | 162 ++++++++++++++++
 tb/tb_coin_credit_return_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coin_credit_return_ctrl_pkg.sv
// Shared definitions for the vending credit/change controller: default sizing,
// default coin values and item prices, and the FSM state encoding.
package coin_credit_return_ctrl_pkg;

  localparam int unsigned DEF_NUM_COINS   = 3;
  localparam int unsigned DEF_NUM_ITEMS   = 4;
  localparam int unsigned DEF_CREDIT_W    = 16;
  localparam int unsigned DEF_WAIT_CYCLES = 100;

  // Index 0 (LSB slice) is the smallest denomination / first item.
  localparam logic [DEF_NUM_COINS*DEF_CREDIT_W-1:0] DEF_COIN_VALUES =
    {16'd1000, 16'd500, 16'd100};
  localparam logic [DEF_NUM_ITEMS*DEF_CREDIT_W-1:0] DEF_ITEM_PRICES =
    {16'd2000, 16'd1000, 16'd500, 16'd400};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RETURN = 1'b1
  } state_t;

endpackage

// File: rtl/coin_credit_return_ctrl_picker.sv
// Combinational change picker: largest coin whose value fits in the given credit.
module coin_change_picker #(
  parameter int unsigned                  N_COINS     = 3,
  parameter int unsigned                  CREDIT_W    = 16,
  parameter logic [N_COINS*CREDIT_W-1:0]  COIN_VALUES = {16'd1000, 16'd500, 16'd100}
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic [N_COINS-1:0]  coin_c,
  output logic [CREDIT_W-1:0] value_c,
  output logic                found_c
);

  // Scan all denominations; order-independent, zero-valued coins never win.
  always_comb begin
    coin_c  = '0;
    value_c = '0;
    found_c = 1'b0;
    for (int i = 0; i < N_COINS; i++) begin
      if ((COIN_VALUES[i*CREDIT_W +: CREDIT_W] <= credit) &&
          (COIN_VALUES[i*CREDIT_W +: CREDIT_W] > value_c)) begin
        coin_c    = '0;
        coin_c[i] = 1'b1;
        value_c   = COIN_VALUES[i*CREDIT_W +: CREDIT_W];
        found_c   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/coin_credit_return_ctrl.sv
// Credit/change controller: accumulates coins, grants purchases, returns change on timeout.
// Optional build macro RETURN_BUTTON_EN adds i_return_request for an immediate return.
module coin_credit_return_ctrl
  import coin_credit_return_ctrl_pkg::*;
#(
  parameter int unsigned                  N_COINS     = DEF_NUM_COINS,
  parameter int unsigned                  N_ITEMS     = DEF_NUM_ITEMS,
  parameter int unsigned                  CREDIT_W    = DEF_CREDIT_W,
  parameter int unsigned                  WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter logic [N_COINS*CREDIT_W-1:0]  COIN_VALUES = DEF_COIN_VALUES,
  parameter logic [N_ITEMS*CREDIT_W-1:0]  ITEM_PRICES = DEF_ITEM_PRICES
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_COINS-1:0]  i_input_coin,
  input  logic [N_ITEMS-1:0]  i_select_item,
`ifdef RETURN_BUTTON_EN
  input  logic                i_return_request,
`endif
  output logic [N_ITEMS-1:0]  o_available_item,
  output logic [N_ITEMS-1:0]  o_output_item,
  output logic [N_COINS-1:0]  o_return_coin,
  output logic [CREDIT_W-1:0] o_credit,
  output logic [31:0]         o_wait_time,
  output logic                o_busy
);

  state_t              state, state_next;
  logic [CREDIT_W-1:0] credit_next;
  logic [31:0]         timer_next;
  logic [N_ITEMS-1:0]  item_next;
  logic [N_COINS-1:0]  coin_next;

  logic                coin_valid, item_valid, reload;
  logic [CREDIT_W-1:0] coin_val, price_val, credit_add;
  logic [CREDIT_W:0]   credit_sum;

  logic [N_COINS-1:0]  pick_coin;
  logic [CREDIT_W-1:0] pick_val;
  logic                pick_found;

  coin_change_picker #(
    .N_COINS     (N_COINS),
    .CREDIT_W    (CREDIT_W),
    .COIN_VALUES (COIN_VALUES)
  ) u_picker (
    .credit  (o_credit),
    .coin_c  (pick_coin),
    .value_c (pick_val),
    .found_c (pick_found)
  );

  assign coin_valid = $onehot(i_input_coin);
  assign item_valid = $onehot(i_select_item);

  // Value of the inserted coin and price of the selected item (one-hot mux).
  always_comb begin
    coin_val = '0;
    for (int i = 0; i < N_COINS; i++)
      if (i_input_coin[i]) coin_val = coin_val | COIN_VALUES[i*CREDIT_W +: CREDIT_W];
  end

  always_comb begin
    price_val = '0;
    for (int i = 0; i < N_ITEMS; i++)
      if (i_select_item[i]) price_val = price_val | ITEM_PRICES[i*CREDIT_W +: CREDIT_W];
  end

  // Availability decoded from registered credit and state.
  always_comb begin
    o_available_item = '0;
    for (int i = 0; i < N_ITEMS; i++)
      o_available_item[i] = (state == ST_IDLE) &&
                            (o_credit >= ITEM_PRICES[i*CREDIT_W +: CREDIT_W]);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_next  = state;
    credit_next = o_credit;
    timer_next  = o_wait_time;
    item_next   = '0;
    coin_next   = '0;
    reload      = 1'b0;
    credit_sum  = '0;
    credit_add  = o_credit;

    case (state)
      ST_IDLE: begin
        if (coin_valid) begin
          credit_sum = {1'b0, o_credit} + {1'b0, coin_val};
          if (credit_sum[CREDIT_W]) begin
            coin_next = i_input_coin;
          end else begin
            credit_add = credit_sum[CREDIT_W-1:0];
            reload     = 1'b1;
          end
        end
        credit_next = credit_add;
        // Purchase sees the credit including a coin added this cycle.
        if (item_valid && (credit_add >= price_val)) begin
          credit_next = credit_add - price_val;
          item_next   = i_select_item;
          reload      = 1'b1;
        end
        if (credit_next == '0) begin
          timer_next = '0;
        end else if (reload) begin
          timer_next = 32'(WAIT_CYCLES);
        end else if (o_wait_time <= 32'd1) begin
          timer_next = '0;
          state_next = ST_RETURN;
        end else begin
          timer_next = o_wait_time - 32'd1;
        end
`ifdef RETURN_BUTTON_EN
        if (i_return_request && (credit_next != '0)) begin
          timer_next = '0;
          state_next = ST_RETURN;
        end
`endif
      end

      ST_RETURN: begin
        timer_next = '0;
        if (pick_found) begin
          coin_next   = pick_coin;
          credit_next = o_credit - pick_val;
        end else begin
          // Residue below the smallest coin (including zero) is dropped.
          credit_next = '0;
          state_next  = ST_IDLE;
        end
      end

      default: begin
        state_next  = ST_IDLE;
        credit_next = '0;
        timer_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_IDLE;
      o_credit      <= '0;
      o_wait_time   <= '0;
      o_output_item <= '0;
      o_return_coin <= '0;
      o_busy        <= 1'b0;
    end else begin
      state         <= state_next;
      o_credit      <= credit_next;
      o_wait_time   <= timer_next;
      o_output_item <= item_next;
      o_return_coin <= coin_next;
      o_busy        <= (state_next == ST_RETURN);
    end
  end

endmodule

// File: tb/tb_coin_credit_return_ctrl.sv
// Self-checking bench for coin_credit_return_ctrl: directed table, corner sequences,
// and random traffic against a behavioural credit/change model.
module tb_coin_credit_return_ctrl;

  localparam int WAIT = 100;
  localparam int MAX_CREDIT = 65535;
`ifdef RETURN_BUTTON_EN
  localparam bit BUTTON_EN = 1'b1;
`else
  localparam bit BUTTON_EN = 1'b0;
`endif

  int coin_v[3]  = '{100, 500, 1000};
  int price_v[4] = '{400, 500, 1000, 2000};

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  input_coin = '0;
  logic [3:0]  select_item = '0;
  logic        return_request = 1'b0;
  logic [3:0]  available_item, output_item;
  logic [2:0]  return_coin;
  logic [15:0] credit;
  logic [31:0] wait_time;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  coin_credit_return_ctrl dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .i_input_coin     (input_coin),
    .i_select_item    (select_item),
`ifdef RETURN_BUTTON_EN
    .i_return_request (return_request),
`endif
    .o_available_item (available_item),
    .o_output_item    (output_item),
    .o_return_coin    (return_coin),
    .o_credit         (credit),
    .o_wait_time      (wait_time),
    .o_busy           (busy)
  );

  // Behavioural model: credit as an integer, change planned up front as a coin queue.
  int        m_credit, m_timer;
  bit        m_ret;
  int        m_q[$];
  logic [2:0] m_coin;
  logic [3:0] m_item;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic [2:0] c, input logic [3:0] s, input logic r);
    input_coin = c; select_item = s; return_request = r;
    @(posedge clk); #1;
  endtask

  task automatic model_reset();
    m_credit = 0; m_timer = 0; m_ret = 0; m_q.delete(); m_coin = '0; m_item = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(3'b000, 4'b0000, 1'b0);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic model_step(input logic [2:0] c, input logic [3:0] s, input logic r);
    bit reload, go;
    int rem;
    m_coin = '0; m_item = '0; reload = 0; go = 0;
    if (!m_ret) begin
      if ($countones(c) == 1) begin
        for (int k = 0; k < 3; k++) if (c[k]) begin
          if (m_credit + coin_v[k] > MAX_CREDIT) m_coin = c;
          else begin m_credit += coin_v[k]; reload = 1; end
        end
      end
      if ($countones(s) == 1) begin
        for (int k = 0; k < 4; k++) if (s[k] && m_credit >= price_v[k]) begin
          m_credit -= price_v[k]; m_item = s; reload = 1;
        end
      end
      if (m_credit == 0) m_timer = 0;
      else if (reload) m_timer = WAIT;
      else begin
        if (m_timer > 0) m_timer--;
        if (m_timer == 0) go = 1;
      end
      if (r && BUTTON_EN && m_credit > 0) begin go = 1; m_timer = 0; end
      if (go) begin
        m_ret = 1; m_q.delete(); rem = m_credit;
        for (int k = 2; k >= 0; k--) begin
          repeat (rem / coin_v[k]) m_q.push_back(k);
          rem = rem % coin_v[k];
        end
      end
    end else begin
      if (m_q.size() > 0) begin
        rem = m_q.pop_front();
        m_coin = 3'(1 << rem);
        m_credit -= coin_v[rem];
      end else begin
        m_credit = 0; m_ret = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [3:0] ea;
    for (int k = 0; k < 4; k++) ea[k] = !m_ret && (m_credit >= price_v[k]);
    check("rnd_credit", 32'(credit), 32'(m_credit));
    check("rnd_timer", wait_time, 32'(m_timer));
    check("rnd_busy", 32'(busy), 32'(m_ret));
    check("rnd_item", 32'(output_item), 32'(m_item));
    check("rnd_coin", 32'(return_coin), 32'(m_coin));
    check("rnd_avail", 32'(available_item), 32'(ea));
  endtask

  task automatic wait_return(output int n);
    n = 0;
    do begin
      step(3'b000, 4'b0000, 1'b0);
      n++;
    end while (return_coin == 3'b000 && n < 300);
  endtask

  typedef struct {
    logic [2:0] coin;
    logic [3:0] sel;
    logic [3:0] item;
    logic [2:0] ret;
    int         cred;
    logic [3:0] avail;
    int         timer;
  } vec_t;

  vec_t vt[15];

  initial begin
    int n;
    logic [2:0] rc;
    logic [3:0] rs;
    logic       rr;
    int         p;

    vt[0]  = '{3'b010, 4'b0000, 4'b0000, 3'b000,  500, 4'b0011, 100};
    vt[1]  = '{3'b010, 4'b0000, 4'b0000, 3'b000, 1000, 4'b0111, 100};
    vt[2]  = '{3'b000, 4'b0100, 4'b0100, 3'b000,    0, 4'b0000,   0};
    vt[3]  = '{3'b000, 4'b0000, 4'b0000, 3'b000,    0, 4'b0000,   0};
    vt[4]  = '{3'b010, 4'b0001, 4'b0001, 3'b000,  100, 4'b0000, 100};
    vt[5]  = '{3'b100, 4'b0000, 4'b0000, 3'b000, 1100, 4'b0111, 100};
    vt[6]  = '{3'b001, 4'b0000, 4'b0000, 3'b000, 1200, 4'b0111, 100};
    vt[7]  = '{3'b001, 4'b0000, 4'b0000, 3'b000, 1300, 4'b0111, 100};
    vt[8]  = '{3'b001, 4'b0000, 4'b0000, 3'b000, 1400, 4'b0111, 100};
    vt[9]  = '{3'b001, 4'b0000, 4'b0000, 3'b000, 1500, 4'b0111, 100};
    vt[10] = '{3'b000, 4'b1000, 4'b0000, 3'b000, 1500, 4'b0111,  99};
    vt[11] = '{3'b011, 4'b0000, 4'b0000, 3'b000, 1500, 4'b0111,  98};
    vt[12] = '{3'b000, 4'b0011, 4'b0000, 3'b000, 1500, 4'b0111,  97};
    vt[13] = '{3'b000, 4'b0001, 4'b0001, 3'b000, 1100, 4'b0111, 100};
    vt[14] = '{3'b000, 4'b0000, 4'b0000, 3'b000, 1100, 4'b0111,  99};

    // Reset state
    do_reset();
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_timer", wait_time, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_coin", 32'(return_coin), 32'd0);
    check("rst_item", 32'(output_item), 32'd0);
    check("rst_avail", 32'(available_item), 32'd0);

    // Directed table: purchases, same-cycle coin+select, refused and invalid events
    for (int i = 0; i < 15; i++) begin
      step(vt[i].coin, vt[i].sel, 1'b0);
      check($sformatf("vec%0d_item", i), 32'(output_item), 32'(vt[i].item));
      check($sformatf("vec%0d_ret", i), 32'(return_coin), 32'(vt[i].ret));
      check($sformatf("vec%0d_credit", i), 32'(credit), 32'(vt[i].cred));
      check($sformatf("vec%0d_avail", i), 32'(available_item), 32'(vt[i].avail));
      check($sformatf("vec%0d_timer", i), wait_time, 32'(vt[i].timer));
    end

    // Timeout return of 1600 as 1000, 500, 100
    do_reset();
    step(3'b100, 4'b0000, 1'b0);
    step(3'b010, 4'b0000, 1'b0);
    step(3'b001, 4'b0000, 1'b0);
    check("t2_credit", 32'(credit), 32'd1600);
    wait_return(n);
    check("t2_latency", 32'(n), 32'(WAIT + 1));
    check("t2_coin0", 32'(return_coin), 32'b100);
    check("t2_cred0", 32'(credit), 32'd600);
    check("t2_busy0", 32'(busy), 32'd1);
    check("t2_avail0", 32'(available_item), 32'd0);
    step(3'b000, 4'b0000, 1'b0);
    check("t2_coin1", 32'(return_coin), 32'b010);
    check("t2_cred1", 32'(credit), 32'd100);
    step(3'b000, 4'b0000, 1'b0);
    check("t2_coin2", 32'(return_coin), 32'b001);
    check("t2_cred2", 32'(credit), 32'd0);
    step(3'b000, 4'b0000, 1'b0);
    check("t2_coin3", 32'(return_coin), 32'b000);
    check("t2_busy3", 32'(busy), 32'd0);

    // Second coin restarts the inactivity window
    do_reset();
    step(3'b001, 4'b0000, 1'b0);
    repeat (59) step(3'b000, 4'b0000, 1'b0);
    check("t3_pre_coin", 32'(return_coin), 32'd0);
    check("t3_pre_timer", wait_time, 32'(WAIT - 59));
    step(3'b001, 4'b0000, 1'b0);
    wait_return(n);
    check("t3_latency", 32'(n), 32'(WAIT + 1));
    check("t3_coin0", 32'(return_coin), 32'b001);
    step(3'b000, 4'b0000, 1'b0);
    check("t3_coin1", 32'(return_coin), 32'b001);
    check("t3_cred1", 32'(credit), 32'd0);

    // Reset in the middle of a return
    do_reset();
    step(3'b100, 4'b0000, 1'b0);
    step(3'b010, 4'b0000, 1'b0);
    wait_return(n);
    check("t6_first", 32'(return_coin), 32'b100);
    reset_n = 1'b0;
    step(3'b000, 4'b0000, 1'b0);
    check("t6_coin", 32'(return_coin), 32'd0);
    check("t6_credit", 32'(credit), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_timer", wait_time, 32'd0);
    reset_n = 1'b1;
    step(3'b000, 4'b0000, 1'b0);
    check("t6_after_coin", 32'(return_coin), 32'd0);
    check("t6_after_busy", 32'(busy), 32'd0);

    // Overflow: coins that would exceed the credit range bounce
    do_reset();
    repeat (65) step(3'b100, 4'b0000, 1'b0);
    step(3'b010, 4'b0000, 1'b0);
    check("ovf_credit", 32'(credit), 32'd65500);
    step(3'b100, 4'b0000, 1'b0);
    check("ovf_bounce1000", 32'(return_coin), 32'b100);
    check("ovf_credit1000", 32'(credit), 32'd65500);
    step(3'b001, 4'b0000, 1'b0);
    check("ovf_bounce100", 32'(return_coin), 32'b001);
    check("ovf_credit100", 32'(credit), 32'd65500);

`ifdef RETURN_BUTTON_EN
    // Return button with 600 credit
    do_reset();
    step(3'b010, 4'b0000, 1'b0);
    step(3'b001, 4'b0000, 1'b0);
    step(3'b000, 4'b0000, 1'b1);
    check("btn_busy", 32'(busy), 32'd1);
    check("btn_credit", 32'(credit), 32'd600);
    step(3'b000, 4'b0000, 1'b0);
    check("btn_coin0", 32'(return_coin), 32'b010);
    step(3'b000, 4'b0000, 1'b0);
    check("btn_coin1", 32'(return_coin), 32'b001);
    check("btn_credit1", 32'(credit), 32'd0);
    step(3'b000, 4'b0000, 1'b0);
    check("btn_idle", 32'(busy), 32'd0);
`endif

    // Random traffic: alternating busy and quiet segments so timeouts occur
    do_reset();
    for (int seg = 0; seg < 16; seg++) begin
      p = (seg % 2 == 0) ? 10 : 1;
      for (int c = 0; c < 300; c++) begin
        rc = ($urandom_range(0, 99) < p) ? 3'($urandom_range(1, 7)) : 3'b000;
        rs = ($urandom_range(0, 99) < p) ? 4'($urandom_range(1, 15)) : 4'b0000;
        rr = ($urandom_range(0, 199) == 0);
        step(rc, rs, rr);
        model_step(rc, rs, rr);
        check_model();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
